dma_copier: RTL
===============

# dma_copier

Word-copy DMA initiator for the single-cycle ARM data-memory bus. It drives the same address, write-enable, write-data and read-data port the CPU uses toward data memory and its memory-mapped peripherals. After a `start` pulse it copies `len` 32-bit words from `src_base` to `dst_base`, one word per two cycles. It requests the bus and advances only while granted. The top level muxes its `a`/`we`/`wd` into data memory when `bus_gnt` is high.

## Interface
- `LEN_W`, default 7: width of the word-count input; maximum transfer is 2^LEN_W−1 words.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src_base`  in  32  source byte address; bits [1:0] ignored (forced 0).
- `dst_base`  in  32  destination byte address; bits [1:0] ignored.
- `len`  in  LEN_W  number of words to move.
- `src_inc`, `dst_inc`  in  1 each  increment address by 4 per word when 1; hold fixed when 0 (peripheral FIFO-style access).
- `fill_mode`  in  1  fill request (see Configuration).
- `fill_value`  in  32  fill pattern (see Configuration).
- `bus_gnt`  in  1  arbiter grant; bus is owned this cycle when high.
- `rd`  in  32  read data from memory; combinational in `a`.
- `bus_req`  out  1  high in every state except IDLE.
- `a`  out  32  byte address to memory.
- `we`  out  1  write enable; memory writes `wd` at the next rising edge.
- `wd`  out  32  write data.
- `busy`  out  1  high from the cycle after `start` accept until DONE ends.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - On `start`: latch `src_base & ~3` → src_ptr, `dst_base & ~3` → dst_ptr, `len` → remaining, and the mode bits.
  - Next state is READ, or DONE if `len == 0`.
- **READ**
  - `a = src_ptr`, `we = 0`.
  - If `bus_gnt`: capture `rd` into the data register, go to WRITE, and advance src_ptr by 4 if `src_inc`.
  - If not granted: hold state.
- **WRITE**
  - `a = dst_ptr`, `wd = data register`, `we = bus_gnt`.
  - If `bus_gnt`: decrement remaining and advance dst_ptr if `dst_inc`.
  - Next state is DONE if remaining was 1, otherwise READ.
  - If not granted: hold state with `we = 0`.
- **DONE**: `done = 1` for exactly one cycle, then IDLE.
- `start` in any state other than IDLE is ignored; no queuing.
- Address arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- `len` counts words, not bytes.
- Overlapping ranges are copied forward, word by word; no overlap protection.
- Accesses to 0xC000_0000 (switches) and 0xC000_0004 (LEDs) are legal and behave exactly as CPU accesses do.
- In IDLE: `a = 0`, `wd = 0`, `we = 0`.

## Timing
- Reset values: state IDLE; `a`, `wd`, pointers, remaining and data register = 0; `we`, `bus_req`, `busy`, `done` = 0.
- Reset mid-transfer: IDLE on the next edge; `we` is 0 in the cycle following the reset edge; the word in flight is not written.
- With continuous grant, N > 0 words: `start` at edge 0, first READ in cycle 1, last write at edge 2N, `done` high in cycle 2N+1.
- `len = 0`: `done` in cycle 1, no bus access.
- Each cycle of `bus_gnt` low in READ or WRITE adds exactly one cycle; no data is lost.
- `we` is never high while `bus_gnt` is low.
- `bus_req` and `busy` fall in the cycle after DONE.

## Configuration
- Feature macro: `DMA_FILL_EN`.
- **Defined:** `fill_mode = 1` at `start` skips READ entirely.
  - Each word is a WRITE of the latched `fill_value` to dst_ptr, one word per granted cycle.
  - N words complete with `done` in cycle N+1.
- **Undefined:** `fill_mode` and `fill_value` are ignored, every transfer is a copy, and the FSM has no fill path. Ports remain for a stable interface.

## Structure
- Package `dma_pkg` holds:
  - the state enum;
  - `WORD_BYTES = 4`;
  - `SW_ADDR = 32'hC000_0000`;
  - `LED_ADDR = 32'hC000_0004`.
- One sub-module: `dma_addr_gen`, instantiated twice (source, destination).
  - Loads base with `[1:0]` cleared.
  - Steps by 4 on `adv & inc`, wraps modulo 2^32.
  - Synchronous reset to 0.

## Test plan
- Copy, full grant: RAM[0..3] = 1, 2, 3, 4; src 0x00, dst 0x40, len 4, both inc → RAM[16..19] = 1, 2, 3, 4; `done` in cycle 9; `busy` for cycles 1–9.
- Grant stalls: same transfer with `bus_gnt` low in cycles 2 and 5 → identical result; `done` in cycle 11; `we` never high while `bus_gnt` is low.
- Peripheral: switches = 0x2A5, src 0xC000_0000, `src_inc` 0, dst 0x80 inc, len 3 → RAM[32..34] = 0x2A5; then src 0x80, dst 0xC000_0004, `dst_inc` 0, len 1 → LEDs = 0x2A5.
- Edge cases:
  - len 0 → `done` in cycle 1, no `we`.
  - `start` while busy → ignored.
  - src 0x43 → reads at 0x40.
  - dst 0xFFFF_FFFC, len 2 → second write at 0x0.
- Reset in cycle 4 of a len-4 copy → only the first word is written; all outputs are at reset values the next cycle; a new `start` then completes normally.
- `DMA_FILL_EN` defined: fill 0xDEAD_BEEF, dst 0x20, len 5 → RAM[8..12] = 0xDEAD_BEEF, `done` in cycle 6. Undefined: same stimulus performs a copy from `src_base`.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the word-copy DMA initiator.
package dma_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } dma_state_e;

   localparam logic [31:0] WORD_BYTES = 32'd4;
   localparam logic [31:0] SW_ADDR    = 32'hC000_0000;
   localparam logic [31:0] LED_ADDR   = 32'hC000_0004;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Word-aligned address pointer: loads a base, steps one word per advance,
// wrapping modulo 2^32.
module dma_addr_gen
   import dma_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [31:0] base_i,
   input  logic        adv_i,
   input  logic        inc_i,
   output logic [31:0] ptr_o,
   output logic [31:0] ptr_nxt_o
);

   logic [31:0] ptr_q;

   assign ptr_nxt_o = inc_i ? (ptr_q + WORD_BYTES) : ptr_q;
   assign ptr_o     = ptr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 32'd0;
      end else if (load_i) begin
         ptr_q <= word_align(base_i);
      end else if (adv_i) begin
         ptr_q <= ptr_nxt_o;
      end else begin
         ptr_q <= ptr_q;
      end
   end

endmodule

// File: rtl/dma_copier.sv
// Word-copy DMA initiator on the single-cycle data-memory bus.
// Optional fill path enabled by defining DMA_FILL_EN.
module dma_copier
   import dma_pkg::*;
#(
   parameter int LEN_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      src_base,
   input  logic [31:0]      dst_base,
   input  logic [LEN_W-1:0] len,
   input  logic             src_inc,
   input  logic             dst_inc,
   input  logic             fill_mode,
   input  logic [31:0]      fill_value,
   input  logic             bus_gnt,
   input  logic [31:0]      rd,
   output logic             bus_req,
   output logic [31:0]      a,
   output logic             we,
   output logic [31:0]      wd,
   output logic             busy,
   output logic             done
);

   dma_state_e       state_q;
   logic [LEN_W-1:0] rem_q;
   logic             src_inc_q;
   logic             dst_inc_q;
   logic [31:0]      a_q;
   logic [31:0]      wd_q;
   logic             we_en_q;
   logic             busy_q;
   logic             bus_req_q;
   logic             done_q;

   logic [31:0] src_ptr_s;
   logic [31:0] src_nxt_s;
   logic [31:0] dst_ptr_s;
   logic [31:0] dst_nxt_s;
   logic        load_s;
   logic        src_adv_s;
   logic        dst_adv_s;

`ifdef DMA_FILL_EN
   logic fill_q;
`else
   logic unused_fill_s;
   assign unused_fill_s = ^{fill_mode, fill_value};
`endif

   assign load_s    = (state_q == S_IDLE) && start;
   assign src_adv_s = (state_q == S_READ) && bus_gnt;
   assign dst_adv_s = (state_q == S_WRITE) && bus_gnt;

   dma_addr_gen u_src_gen (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load_s),
      .base_i    (src_base),
      .adv_i     (src_adv_s),
      .inc_i     (src_inc_q),
      .ptr_o     (src_ptr_s),
      .ptr_nxt_o (src_nxt_s)
   );

   dma_addr_gen u_dst_gen (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load_s),
      .base_i    (dst_base),
      .adv_i     (dst_adv_s),
      .inc_i     (dst_inc_q),
      .ptr_o     (dst_ptr_s),
      .ptr_nxt_o (dst_nxt_s)
   );

   // Write strobe must follow grant within the cycle; reset kills an in-flight write.
   assign we      = we_en_q && bus_gnt && !reset;
   assign a       = a_q;
   assign wd      = wd_q;
   assign busy    = busy_q;
   assign bus_req = bus_req_q;
   assign done    = done_q;

   // Transfer FSM; bus outputs are registered for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rem_q     <= '0;
         src_inc_q <= 1'b0;
         dst_inc_q <= 1'b0;
         a_q       <= 32'd0;
         wd_q      <= 32'd0;
         we_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         bus_req_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef DMA_FILL_EN
         fill_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  rem_q     <= len;
                  src_inc_q <= src_inc;
                  dst_inc_q <= dst_inc;
                  busy_q    <= 1'b1;
                  bus_req_q <= 1'b1;
                  if (len == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
`ifdef DMA_FILL_EN
                  else if (fill_mode) begin
                     fill_q  <= 1'b1;
                     state_q <= S_WRITE;
                     a_q     <= word_align(dst_base);
                     wd_q    <= fill_value;
                     we_en_q <= 1'b1;
                  end
`endif
                  else begin
`ifdef DMA_FILL_EN
                     fill_q  <= 1'b0;
`endif
                     state_q <= S_READ;
                     a_q     <= word_align(src_base);
                  end
               end
            end
            S_READ: begin
               if (bus_gnt) begin
                  wd_q    <= rd;
                  state_q <= S_WRITE;
                  a_q     <= dst_ptr_s;
                  we_en_q <= 1'b1;
               end
            end
            S_WRITE: begin
               if (bus_gnt) begin
                  rem_q <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     we_en_q <= 1'b0;
                     a_q     <= 32'd0;
                     wd_q    <= 32'd0;
                  end
`ifdef DMA_FILL_EN
                  else if (fill_q) begin
                     a_q <= dst_nxt_s;
                  end
`endif
                  else begin
                     state_q <= S_READ;
                     a_q     <= src_ptr_s;
                     we_en_q <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               state_q   <= S_IDLE;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               bus_req_q <= 1'b0;
               a_q       <= 32'd0;
               wd_q      <= 32'd0;
               we_en_q   <= 1'b0;
            end
            default: begin
               state_q   <= S_IDLE;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               bus_req_q <= 1'b0;
               a_q       <= 32'd0;
               wd_q      <= 32'd0;
               we_en_q   <= 1'b0;
            end
         endcase
      end
   end

   logic unused_nxt_s;
   assign unused_nxt_s = ^src_nxt_s;

endmodule
